// File: rtl/ln_sched_pkg.sv
// rtl/ln_sched_pkg.sv - shared state, tag and bus constants for the LN command scheduler
package ln_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WT_RD,
        ST_RD,
        ST_WAIT,
        NM,
        WB_WAIT,
        FIN
    } state_e;

    // rd_tag encodings seen by the DMA read queue
    localparam logic [1:0] TAG_WT = 2'd0;
    localparam logic [1:0] TAG_ST = 2'd1;
    localparam logic [1:0] TAG_NM = 2'd2;

    // Weight words are fetched as whole AXI data beats
    localparam int AXI_DAT_WIDTH  = 512;
    localparam int AXI_WORD_BYTES = AXI_DAT_WIDTH / 8;

endpackage

// File: rtl/ln_addr_walker.sv
// rtl/ln_addr_walker.sv - incremental base/row/group address pointer with group counter
module ln_addr_walker
    import ln_sched_pkg::*;
#(
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW-1:0] surf_i,
    input  logic [AW-1:0] line_i,
    input  logic [CW-1:0] count_i,
    input  logic          rewind_i,
    input  logic          restart_i,
    input  logic          advance_i,
    input  logic          row_step_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] surf_q, surf_d;
    logic [AW-1:0] line_q, line_d;
    logic [CW-1:0] cnt_max_q, cnt_max_d;
    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next pointer state: job load wins, then rewind to base, then row/group stepping
    always_comb begin
        base_d    = base_q;
        surf_d    = surf_q;
        line_d    = line_q;
        cnt_max_d = cnt_max_q;
        row_d     = row_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            base_d    = base_i;
            surf_d    = surf_i;
            line_d    = line_i;
            cnt_max_d = count_i;
            row_d     = base_i;
            ptr_d     = base_i;
            cnt_d     = '0;
        end else if (rewind_i) begin
            row_d = base_q;
            ptr_d = base_q;
            cnt_d = '0;
        end else begin
            if (row_step_i) begin
                row_d = row_q + line_q;
            end
            if (restart_i) begin
                ptr_d = row_q;
                cnt_d = '0;
            end else if (advance_i) begin
                ptr_d = ptr_q + surf_q;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Pointer and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            surf_q    <= '0;
            line_q    <= '0;
            cnt_max_q <= '0;
            row_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            base_q    <= base_d;
            surf_q    <= surf_d;
            line_q    <= line_d;
            cnt_max_q <= cnt_max_d;
            row_q     <= row_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign addr_o = ptr_q;
    assign last_o = (cnt_q == (cnt_max_q - CW'(1)));

endmodule

// File: rtl/ln_cmd_scheduler.sv
// rtl/ln_cmd_scheduler.sv - turns one LN job into weight/stats/normalize DMA commands
module ln_cmd_scheduler
    import ln_sched_pkg::*;
#(
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cfg_rms,
    input  logic [CW-1:0] cfg_pixels,
    input  logic [CW-1:0] cfg_ch_groups,
    input  logic [CW-1:0] cfg_wt_beats,
    input  logic [AW-1:0] cfg_wt_base,
    input  logic [AW-1:0] cfg_in_base,
    input  logic [AW-1:0] cfg_out_base,
    input  logic [AW-1:0] cfg_in_surf,
    input  logic [AW-1:0] cfg_in_line,
    input  logic [AW-1:0] cfg_out_surf,
    input  logic [AW-1:0] cfg_out_line,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_tag,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic          st_start,
    input  logic          st_done,
    input  logic          wb_done,
    output logic          ln_mode,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic          st_first_q;
    logic          rd_done_q, rd_done_d;
    logic          wr_done_q, wr_done_d;
    logic [CW-1:0] pix_q, pix_d;
    logic [CW-1:0] pix_max_q;
    logic          ln_mode_q;
    logic          done_q;

    logic          job_load;
    logic          rewind;
    logic          wt_adv;
    logic          in_restart, in_adv;
    logic          out_restart, out_adv;
    logic          row_step;
    logic [AW-1:0] wt_addr, in_addr, out_addr;
    logic          wt_last, in_last, out_last;

    logic          rd_valid_c, wr_valid_c;
    logic [AW-1:0] rd_addr_c, wr_addr_c;
    logic [1:0]    rd_tag_c;

    assign job_load = (state_q == IDLE) && start;

    ln_addr_walker #(.AW(AW), .CW(CW)) u_wt_walk (
        .clk        (clk),
        .rst        (rst),
        .load_i     (job_load),
        .base_i     (cfg_wt_base),
        .surf_i     (AW'(AXI_WORD_BYTES)),
        .line_i     ('0),
        .count_i    (cfg_wt_beats),
        .rewind_i   (rewind),
        .restart_i  (1'b0),
        .advance_i  (wt_adv),
        .row_step_i (1'b0),
        .addr_o     (wt_addr),
        .last_o     (wt_last)
    );

    ln_addr_walker #(.AW(AW), .CW(CW)) u_in_walk (
        .clk        (clk),
        .rst        (rst),
        .load_i     (job_load),
        .base_i     (cfg_in_base),
        .surf_i     (cfg_in_surf),
        .line_i     (cfg_in_line),
        .count_i    (cfg_ch_groups),
        .rewind_i   (rewind),
        .restart_i  (in_restart),
        .advance_i  (in_adv),
        .row_step_i (row_step),
        .addr_o     (in_addr),
        .last_o     (in_last)
    );

    ln_addr_walker #(.AW(AW), .CW(CW)) u_out_walk (
        .clk        (clk),
        .rst        (rst),
        .load_i     (job_load),
        .base_i     (cfg_out_base),
        .surf_i     (cfg_out_surf),
        .line_i     (cfg_out_line),
        .count_i    (cfg_ch_groups),
        .rewind_i   (rewind),
        .restart_i  (out_restart),
        .advance_i  (out_adv),
        .row_step_i (row_step),
        .addr_o     (out_addr),
        .last_o     (out_last)
    );

    // Next state, command outputs and walker strobes
    always_comb begin
        state_d     = state_q;
        rd_done_d   = rd_done_q;
        wr_done_d   = wr_done_q;
        pix_d       = pix_q;
        rd_valid_c  = 1'b0;
        rd_addr_c   = '0;
        rd_tag_c    = TAG_WT;
        wr_valid_c  = 1'b0;
        wr_addr_c   = '0;
        rewind      = 1'b0;
        wt_adv      = 1'b0;
        in_restart  = 1'b0;
        in_adv      = 1'b0;
        out_restart = 1'b0;
        out_adv     = 1'b0;
        row_step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pix_d = '0;
                    if (cfg_pixels == '0) begin
                        state_d = FIN;
                    end else if (cfg_wt_beats == '0) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = WT_RD;
                    end
                end
            end
            WT_RD: begin
                rd_valid_c = 1'b1;
                rd_addr_c  = wt_addr;
                rd_tag_c   = TAG_WT;
                if (rd_ready) begin
                    wt_adv = 1'b1;
                    if (wt_last) begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                // First cycle only rewinds the group pointer to the row; reads start next cycle
                if (st_first_q) begin
                    in_restart = 1'b1;
                end else begin
                    rd_valid_c = 1'b1;
                    rd_addr_c  = in_addr;
                    rd_tag_c   = TAG_ST;
                    if (rd_ready) begin
                        in_adv = 1'b1;
                        if (in_last) begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (st_done) begin
                    in_restart  = 1'b1;
                    out_restart = 1'b1;
                    rd_done_d   = 1'b0;
                    wr_done_d   = 1'b0;
                    state_d     = NM;
                end
            end
            NM: begin
                if (!rd_done_q) begin
                    rd_valid_c = 1'b1;
                    rd_addr_c  = in_addr;
                    rd_tag_c   = TAG_NM;
                    if (rd_ready) begin
                        in_adv = 1'b1;
                        if (in_last) begin
                            rd_done_d = 1'b1;
                        end
                    end
                end
                if (!wr_done_q) begin
                    wr_valid_c = 1'b1;
                    wr_addr_c  = out_addr;
                    if (wr_ready) begin
                        out_adv = 1'b1;
                        if (out_last) begin
                            wr_done_d = 1'b1;
                        end
                    end
                end
                if (rd_done_d && wr_done_d) begin
                    state_d = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (wb_done) begin
                    row_step = 1'b1;
                    pix_d    = pix_q + CW'(1);
                    if (pix_d == pix_max_q) begin
                        state_d = FIN;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            FIN: begin
                // Park the pointers on their bases between jobs
                rewind  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, per-pixel progress and NM channel completion flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            st_first_q <= 1'b0;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            pix_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_first_q <= (state_d == ST_RD) && (state_q != ST_RD);
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
            pix_q      <= pix_d;
            done_q     <= (state_q == FIN);
        end
    end

    // Job-level config captured on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_max_q <= '0;
            ln_mode_q <= 1'b0;
        end else if (job_load) begin
            pix_max_q <= cfg_pixels;
            ln_mode_q <= cfg_rms;
        end
    end

    assign rd_valid = rd_valid_c;
    assign rd_addr  = rd_addr_c;
    assign rd_tag   = rd_tag_c;
    assign wr_valid = wr_valid_c;
    assign wr_addr  = wr_addr_c;
    assign st_start = (state_q == ST_RD) && st_first_q;
    assign ln_mode  = ln_mode_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule
